datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 185 ++++++++++++++++++
 tb/tb_datapath.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// ============================================================================
// datapath -- 32-bit bus-based register file, ALU and 64-bit Z result register.
// Optional multiply/divide: define DATAPATH_MULDIV_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        PCin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Zin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        InPortIn,
  input  logic        R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic        R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        PCout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHighOut,
  input  logic        ZLowOut,
  input  logic        MDRout,
  input  logic        InPortOut,
  input  logic        incPC,
  input  logic        read,
  input  logic [4:0]  opcode,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut
);

  localparam int unsigned NUM_GPR = 16;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [NUM_GPR-1:0] gpr_in;
  logic [NUM_GPR-1:0] gpr_out;
  logic [31:0]        gpr [NUM_GPR];

  logic [31:0] pc, hi, lo, y, mar, mdr, in_port;
  logic [63:0] z;
  logic [31:0] bus;
  logic [63:0] alu_result;

  assign gpr_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign gpr_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  // Lowest-priority source is assigned first so later assignments win.
  always_comb begin
    bus = '0;
    if (InPortOut) bus = in_port;
    if (MDRout)    bus = mdr;
    if (PCout)     bus = pc;
    if (ZLowOut)   bus = z[31:0];
    if (ZHighOut)  bus = z[63:32];
    if (LOout)     bus = lo;
    if (HIout)     bus = hi;
    for (int i = NUM_GPR - 1; i >= 0; i--) begin
      if (gpr_out[i]) bus = gpr[i];
    end
  end

  assign BusMuxOut = bus;

  // ---------------------------------------------------------------- ALU ----
  logic [4:0]  shamt;
  logic [32:0] sum_ext;
  logic [32:0] diff_ext;
  logic [31:0] sra;
  logic [63:0] ror_wide;
  logic [63:0] rol_wide;

  assign shamt    = bus[4:0];
  assign sum_ext  = {1'b0, y} + {1'b0, bus};
  assign diff_ext = {1'b0, y} - {1'b0, bus};
  assign sra      = $signed(y) >>> shamt;
  assign ror_wide = {y, y} >> shamt;
  assign rol_wide = {y, y} << shamt;

`ifdef DATAPATH_MULDIV_EN
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;

  assign product = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});

  // Zero divisor yields zero; the single overflowing case wraps explicitly.
  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (bus == 32'd0) begin
      quotient  = '0;
      remainder = '0;
    end else if (y == 32'h8000_0000 && bus == 32'hFFFF_FFFF) begin
      quotient  = y;
      remainder = '0;
    end else begin
      quotient  = $signed(y) / $signed(bus);
      remainder = $signed(y) % $signed(bus);
    end
  end
`endif

  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_ADD:  alu_result = {31'b0, sum_ext};
      OP_SUB:  alu_result = {31'b0, diff_ext};
      OP_AND:  alu_result = {32'b0, y & bus};
      OP_OR:   alu_result = {32'b0, y | bus};
      OP_SHR:  alu_result = {32'b0, y >> shamt};
      OP_SHRA: alu_result = {32'b0, sra};
      OP_SHL:  alu_result = {32'b0, y << shamt};
      OP_ROR:  alu_result = {32'b0, ror_wide[31:0]};
      OP_ROL:  alu_result = {32'b0, rol_wide[63:32]};
      OP_NEG:  alu_result = {32'b0, 32'd0 - bus};
      OP_NOT:  alu_result = {32'b0, ~bus};
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  alu_result = product;
      OP_DIV:  alu_result = {remainder, quotient};
`endif
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------- registers ----
  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    always_ff @(posedge clock or negedge clear) begin
      if (!clear)         gpr[g] <= '0;
      else if (gpr_in[g]) gpr[g] <= bus;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)     pc <= '0;
    else if (incPC) pc <= pc + 32'd1;
    else if (PCin)  pc <= bus;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hi      <= '0;
      lo      <= '0;
      y       <= '0;
      mar     <= '0;
      mdr     <= '0;
      in_port <= '0;
      z       <= '0;
    end else begin
      if (HIin)     hi      <= bus;
      if (LOin)     lo      <= bus;
      if (Yin)      y       <= bus;
      if (MARin)    mar     <= bus;
      if (MDRin)    mdr     <= read ? Mdatain : bus;
      if (InPortIn) in_port <= Mdatain;
      if (Zin)      z       <= alu_result;
    end
  end

  // MAR feeds the memory address port outside this block.
  logic unused_mar;
  assign unused_mar = ^mar;

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ============================================================================
// tb_datapath -- directed self-checking bench for datapath.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic        PCin, HIin, LOin, Zin, MARin, MDRin, Yin, InPortIn;
  logic        PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut;
  logic        incPC, read;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut;

  int total = 0;
  int bad   = 0;

  datapath dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(PCin), .HIin(HIin), .LOin(LOin), .Zin(Zin), .MARin(MARin),
    .MDRin(MDRin), .Yin(Yin), .InPortIn(InPortIn),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut),
    .ZLowOut(ZLowOut), .MDRout(MDRout), .InPortOut(InPortOut),
    .incPC(incPC), .read(read), .opcode(opcode), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rin = '0; rout = '0;
    PCin = 0; HIin = 0; LOin = 0; Zin = 0; MARin = 0; MDRin = 0; Yin = 0; InPortIn = 0;
    PCout = 0; HIout = 0; LOout = 0; ZHighOut = 0; ZLowOut = 0; MDRout = 0; InPortOut = 0;
    incPC = 0; read = 0; opcode = '0;
  endtask

  // One clock edge, then release all controls shortly after it.
  task automatic cycle();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic mdr_set(input logic [31:0] v);
    Mdatain = v; read = 1; MDRin = 1;
    cycle();
  endtask

  task automatic load_reg(input int k, input logic [31:0] v);
    mdr_set(v);
    MDRout = 1; rin[k] = 1;
    cycle();
  endtask

  task automatic check_reg(input string tag, input int k, input logic [31:0] exp);
    rout[k] = 1; #1;
    check(tag, BusMuxOut, exp);
    rout[k] = 0; #1;
  endtask

  task automatic check_z(input string tag, input logic [31:0] lo_exp, input logic [31:0] hi_exp);
    ZLowOut = 1; #1;
    check({tag, ".lo"}, BusMuxOut, lo_exp);
    ZLowOut = 0; ZHighOut = 1; #1;
    check({tag, ".hi"}, BusMuxOut, hi_exp);
    ZHighOut = 0; #1;
  endtask

  // Y <- a, R8 <- b, then Z <- Y op R8.
  task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lo_exp, input logic [31:0] hi_exp);
    load_reg(8, b);
    mdr_set(a);
    MDRout = 1; Yin = 1;
    cycle();
    rout[8] = 1; opcode = op; Zin = 1;
    cycle();
    check_z(tag, lo_exp, hi_exp);
  endtask

  initial begin
    idle();
    Mdatain = '0;
    clear = 0;
    repeat (2) @(posedge clock);
    #1 clear = 1;

    check_reg("reset.r0", 0, 32'h0);
    PCout = 1; #1; check("reset.pc", BusMuxOut, 32'h0); PCout = 0;
    check_z("reset.z", 32'h0, 32'h0);
    #1 check("bus.idle", BusMuxOut, 32'h0);

    // NEG sequence through R0 and R5
    mdr_set(32'h1);
    MDRout = 1; rin[0] = 1; cycle();
    rout[0] = 1; opcode = 5'b10001; Zin = 1; cycle();
    ZLowOut = 1; rin[5] = 1; cycle();
    check_reg("neg.r5", 5, 32'hFFFF_FFFF);

    // ADD sequence through R6, R7, R4
    load_reg(6, 32'd30);
    load_reg(7, 32'd25);
    rout[6] = 1; Yin = 1; cycle();
    rout[7] = 1; opcode = 5'b00011; Zin = 1; cycle();
    ZLowOut = 1; rin[4] = 1; cycle();
    check_reg("add.r4", 4, 32'h37);

    alu("add.carry", 5'b00011, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'h1);
    alu("sub.borrow", 5'b00100, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'h1);
    alu("sub", 5'b00100, 32'd7, 32'd5, 32'h2, 32'h0);
    alu("and", 5'b00101, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 32'h0);
    alu("or", 5'b00110, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0, 32'h0);
    alu("shr", 5'b00111, 32'h8000_0013, 32'h4, 32'h0800_0001, 32'h0);
    alu("shr.mask", 5'b00111, 32'h8000_0013, 32'h24, 32'h0800_0001, 32'h0);
    alu("shra", 5'b01000, 32'h8000_0013, 32'h4, 32'hF800_0001, 32'h0);
    alu("shl", 5'b01001, 32'h8000_0013, 32'h4, 32'h0000_0130, 32'h0);
    alu("ror", 5'b01010, 32'h8000_0013, 32'h4, 32'h3800_0001, 32'h0);
    alu("rol", 5'b01011, 32'h8000_0013, 32'h4, 32'h0000_0138, 32'h0);
    alu("ror.zero", 5'b01010, 32'h8000_0013, 32'h0, 32'h8000_0013, 32'h0);
    alu("shra.zero", 5'b01000, 32'h8000_0013, 32'h0, 32'h8000_0013, 32'h0);
    alu("not", 5'b10010, 32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0);
    alu("unlisted.0", 5'b00000, 32'h1234_5678, 32'h1, 32'h0, 32'h0);
    alu("unlisted.c", 5'b01100, 32'h1234_5678, 32'h1, 32'h0, 32'h0);
`ifdef DATAPATH_MULDIV_EN
    alu("mul", 5'b01111, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 32'hFFFF_FFFF);
    alu("div", 5'b10000, 32'd25, 32'd4, 32'd6, 32'd1);
    alu("div.neg", 5'b10000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    alu("div.zero", 5'b10000, 32'd25, 32'd0, 32'h0, 32'h0);
`else
    alu("mul.off", 5'b01111, 32'd6, 32'hFFFF_FFF9, 32'h0, 32'h0);
    alu("div.off", 5'b10000, 32'd25, 32'd4, 32'h0, 32'h0);
`endif

    // Bus priority
    load_reg(1, 32'd5);
    load_reg(2, 32'd9);
    rout[1] = 1; rout[2] = 1; #1; check("prio.r1_r2", BusMuxOut, 32'd5); idle();
    mdr_set(32'hCAFE_0001);
    MDRout = 1; HIin = 1; cycle();
    rout[15] = 1; HIout = 1; #1; check("prio.r15_hi", BusMuxOut, 32'h0); idle();
    HIout = 1; ZLowOut = 1; #1; check("prio.hi_zlo", BusMuxOut, 32'hCAFE_0001); idle();

    // PC increment and wrap
    mdr_set(32'h7FFF_FFFF);
    MDRout = 1; PCin = 1; cycle();
    incPC = 1; cycle();
    PCout = 1; #1; check("pc.inc", BusMuxOut, 32'h8000_0000); idle();
    mdr_set(32'hFFFF_FFFF);
    MDRout = 1; PCin = 1; cycle();
    rout[1] = 1; PCin = 1; incPC = 1; cycle();
    PCout = 1; #1; check("pc.wrap", BusMuxOut, 32'h0); idle();

    // MDR from bus, InPort, self-load
    Mdatain = 32'hDEAD_BEEF;
    rout[2] = 1; MDRin = 1; read = 0; cycle();
    MDRout = 1; #1; check("mdr.bus", BusMuxOut, 32'd9); idle();
    Mdatain = 32'h1234_ABCD; InPortIn = 1; cycle();
    InPortOut = 1; #1; check("inport", BusMuxOut, 32'h1234_ABCD); idle();
    rout[2] = 1; rin[2] = 1; cycle();
    check_reg("self.r2", 2, 32'd9);

    // Asynchronous reset between edges
    load_reg(3, 32'hA5A5_A5A5);
    check_reg("r3.load", 3, 32'hA5A5_A5A5);
    clear = 0; #1;
    check_reg("clear.r3", 3, 32'h0);
    opcode = 5'b10010; Zin = 1; incPC = 1; rin[3] = 1;
    cycle();
    clear = 1;
    check_z("clear.z", 32'h0, 32'h0);
    PCout = 1; #1; check("clear.pc", BusMuxOut, 32'h0); idle();
    check_reg("clear.r3_after", 3, 32'h0);
    load_reg(3, 32'h7);
    check_reg("resume.r3", 3, 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
